// File: rtl/audio_sample_writer.sv
// Mixes two voices, attenuates, and hands one sample per CLK_DIV clocks to the codec FIFO.
// Latency: capture on tick, strobe 2 cycles later at earliest; waits while the FIFO is full, dropping and counting new ticks.
module audio_sample_writer #(
  parameter int unsigned CLK_DIV = 1042
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] voice_a,
  input  logic [31:0] voice_b,
  input  logic [2:0]  volume,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        busy,
  output logic [7:0]  overrun_count
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_WRITE = 2'd2;
  localparam logic [15:0] LAST    = 16'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [31:0] sample_q;
  logic [31:0] chan_q;
  logic [32:0] sum;
  logic [31:0] sat;
  logic [31:0] mixed;

  assign tick = enable && (tick_cnt == LAST);

  // Overflow shows up as disagreement between the two top bits of the 33-bit sum.
  always_comb begin
    sum = {voice_a[31], voice_a} + {voice_b[31], voice_b};
    sat = sum[31:0];
    if (sum[32] != sum[31]) begin
      sat = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    mixed = $signed(sat) >>> volume;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!enable || tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      sample_q <= '0;
      chan_q   <= '0;
    end else if (!enable) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state    <= S_WAIT;
            sample_q <= mixed;
          end
        end
        S_WAIT: begin
          if (audio_out_allowed) begin
            state  <= S_WRITE;
            chan_q <= sample_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A tick that finds the pipeline occupied loses its sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_count <= '0;
    end else if (tick && state != S_IDLE && overrun_count != 8'hFF) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end

  assign write_audio_out         = (state == S_WRITE);
  assign busy                    = (state != S_IDLE);
  assign left_channel_audio_out  = chan_q;
  assign right_channel_audio_out = chan_q;

endmodule

// File: tb/tb_audio_sample_writer.sv
// Scoreboard bench for audio_sample_writer with CLK_DIV=4 and directed vectors.
module tb_audio_sample_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] voice_a = '0;
  logic [31:0] voice_b = '0;
  logic [2:0]  volume = '0;
  logic        audio_out_allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        busy;
  logic [7:0]  overrun_count;

  audio_sample_writer #(.CLK_DIV(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable                  (enable),
    .voice_a                 (voice_a),
    .voice_b                 (voice_b),
    .volume                  (volume),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy),
    .overrun_count           (overrun_count)
  );

  always #5 clock = ~clock;

  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          strobe_cnt = 0;
  int          n;
  int          busy_low;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: every strobe must match the oldest outstanding expected sample.
  always @(negedge clock) begin
    if (reset && write_audio_out) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check("strobe_without_sample", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("left_channel", left_channel_audio_out, mon_exp);
        check("right_channel", right_channel_audio_out, mon_exp);
      end
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic wait_strobes(input int want, input int budget, input bit chk_period);
    int start;
    int seen;
    int last;
    bit have_last;
    start = strobe_cnt;
    seen = strobe_cnt;
    last = 0;
    have_last = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (strobe_cnt != seen) begin
        seen = strobe_cnt;
        if (chk_period && have_last) check("strobe_period", 32'(cyc - last), 32'd4);
        last = cyc;
        have_last = 1'b1;
      end
      if (strobe_cnt - start >= want) break;
    end
    check("strobe_count", 32'(strobe_cnt - start), 32'(want));
  endtask

  task automatic wait_busy(input int budget, output int steps);
    steps = 0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      steps++;
      if (busy) break;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] vol, input logic [31:0] expv);
    voice_a = a;
    voice_b = b;
    volume = vol;
    audio_out_allowed = 1'b1;
    exp_q.push_back(expv);
    enable = 1'b1;
    wait_strobes(1, 20, 1'b0);
    enable = 1'b0;
    step(1);
  endtask

  initial begin
    step(3);
    check("rst_write", 32'(write_audio_out), 32'd0);
    check("rst_left", left_channel_audio_out, 32'd0);
    check("rst_right", right_channel_audio_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_count), 32'd0);
    reset = 1'b1;
    step(1);

    // Steady stream: 100 + -30 = 70, one strobe every 4 cycles.
    voice_a = 32'd100;
    voice_b = 32'hFFFF_FFE2;
    volume = 3'd0;
    audio_out_allowed = 1'b1;
    repeat (3) exp_q.push_back(32'd70);
    enable = 1'b1;
    wait_strobes(3, 40, 1'b1);
    enable = 1'b0;
    step(1);
    check("stream_overrun", 32'(overrun_count), 32'd0);

    run_one(32'h7FFF_FFF0, 32'h0000_0100, 3'd1, 32'h3FFF_FFFF);
    run_one(32'h8000_0000, 32'h8000_0000, 3'd0, 32'h8000_0000);
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0, 32'h7FFF_FFFF);
    run_one(32'hFFFF_FF9C, 32'hFFFF_FFE4, 3'd3, 32'hFFFF_FFF0);
    run_one(32'd1000, 32'd24, 3'd7, 32'd8);

    // FIFO blocked for 10 ticks: first sample survives, later voices ignored.
    audio_out_allowed = 1'b0;
    voice_a = 32'd5;
    voice_b = 32'd6;
    volume = 3'd0;
    exp_q.push_back(32'd11);
    enable = 1'b1;
    wait_busy(20, n);
    voice_a = 32'd999;
    busy_low = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!busy) busy_low++;
      if (overrun_count == 8'd10) break;
    end
    check("blocked_overrun", 32'(overrun_count), 32'd10);
    check("blocked_busy_low", 32'(busy_low), 32'd0);
    audio_out_allowed = 1'b1;
    wait_strobes(1, 10, 1'b0);
    enable = 1'b0;
    step(1);
    check("blocked_overrun_after", 32'(overrun_count), 32'd10);
    check("blocked_idle", 32'(busy), 32'd0);

    // Long block: counter saturates, then enable drop abandons the pending sample.
    audio_out_allowed = 1'b0;
    voice_a = 32'd1;
    voice_b = 32'd1;
    enable = 1'b1;
    step(1230);
    check("sat_overrun", 32'(overrun_count), 32'd255);
    check("sat_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    step(1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_overrun_kept", 32'(overrun_count), 32'd255);

    // Enable dropped in WAIT, then re-raised: first tick 4 cycles later.
    enable = 1'b1;
    wait_busy(20, n);
    enable = 1'b0;
    step(1);
    check("wait_drop_busy", 32'(busy), 32'd0);
    audio_out_allowed = 1'b1;
    voice_a = 32'd1;
    voice_b = 32'd2;
    exp_q.push_back(32'd3);
    enable = 1'b1;
    wait_busy(20, n);
    check("reenable_latency", 32'(n), 32'd4);
    wait_strobes(1, 10, 1'b0);
    enable = 1'b0;
    step(1);

    // Asynchronous reset pulse between edges while waiting.
    audio_out_allowed = 1'b0;
    voice_a = 32'd7;
    voice_b = 32'd8;
    enable = 1'b1;
    wait_busy(20, n);
    step(1);
    #2 reset = 1'b0;
    #1;
    check("arst_write", 32'(write_audio_out), 32'd0);
    check("arst_left", left_channel_audio_out, 32'd0);
    check("arst_right", right_channel_audio_out, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_overrun", 32'(overrun_count), 32'd0);
    reset = 1'b1;
    audio_out_allowed = 1'b1;
    exp_q.push_back(32'd15);
    wait_busy(20, n);
    check("arst_restart_latency", 32'(n), 32'd4);
    wait_strobes(1, 10, 1'b0);
    enable = 1'b0;
    step(2);
    check("leftover_samples", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
